// File: rtl/adder_nbit_reg.sv
// Parameterized N-bit registered ripple-carry adder producing a full N+1 bit sum.
// Define ADDER_NBIT_PIPE_EN to split the carry chain at N/2 behind a register (latency 2).

module adder_nbit_reg_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module adder_nbit_reg_rca #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);
    // Carries live in per-bit scopes so each link of the chain is its own net.
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic ci, co;
        if (i == 0) begin : g_c0
            assign ci = c_i;
        end else begin : g_cn
            assign ci = g_bit[i-1].co;
        end
        adder_nbit_reg_fa u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (ci),
            .s_o (s_o[i]),
            .c_o (co)
        );
    end
    assign c_o = g_bit[W-1].co;
endmodule

module adder_nbit_reg #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum,
    output logic         out_valid
);
`ifdef ADDER_NBIT_PIPE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    logic [N:0]        sum_q, sum_d, res;
    logic [STAGES:1]   vld_pipe_q;
    logic              ld;

`ifdef ADDER_NBIT_PIPE_EN
    localparam int L = N / 2;
    localparam int H = N - L;

    logic [H-1:0] a_hi_q, b_hi_q, s_hi;
    logic         cm_d, cm_q, co_hi;

    // Low half resolves in the first stage; only its sum bits and carry travel on.
    if (L > 0) begin : g_lo
        logic [L-1:0] s_lo, lo_q;
        logic         c_lo;
        adder_nbit_reg_rca #(.W(L)) u_lo (
            .a_i (a[L-1:0]),
            .b_i (b[L-1:0]),
            .c_i (1'b0),
            .s_o (s_lo),
            .c_o (c_lo)
        );
        always_ff @(posedge clk or posedge rst) begin
            if (rst)           lo_q <= '0;
            else if (in_valid) lo_q <= s_lo;
        end
        assign cm_d = c_lo;
        assign res  = {co_hi, s_hi, lo_q};
    end else begin : g_nolo
        assign cm_d = 1'b0;
        assign res  = {co_hi, s_hi};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_hi_q <= '0;
            b_hi_q <= '0;
            cm_q   <= 1'b0;
        end else if (in_valid) begin
            a_hi_q <= a[N-1:L];
            b_hi_q <= b[N-1:L];
            cm_q   <= cm_d;
        end
    end

    adder_nbit_reg_rca #(.W(H)) u_hi (
        .a_i (a_hi_q),
        .b_i (b_hi_q),
        .c_i (cm_q),
        .s_o (s_hi),
        .c_o (co_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
    end
    assign ld = vld_pipe_q[1];
`else
    logic [N-1:0] s_full;
    logic         co_full;

    adder_nbit_reg_rca #(.W(N)) u_rca (
        .a_i (a),
        .b_i (b),
        .c_i (1'b0),
        .s_o (s_full),
        .c_o (co_full)
    );
    assign res = {co_full, s_full};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= in_valid;
    end
    assign ld = in_valid;
`endif

    // sum only loads on a qualified result, so idle-cycle garbage never reaches it.
    assign sum_d = ld ? res : sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign sum       = sum_q;
    assign out_valid = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_adder_nbit_reg.sv
// Bench for adder_nbit_reg at N=1, 10 and 64 against a delay-line model of a+b.
module tb_adder_nbit_reg;
`ifdef ADDER_NBIT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vin = 1'b0;
    logic [0:0]  a1 = '0, b1 = '0;
    logic [9:0]  a10 = '0, b10 = '0;
    logic [63:0] a64 = '0, b64 = '0;
    logic [1:0]  s1;
    logic [10:0] s10;
    logic [64:0] s64;
    logic        ov1, ov10, ov64;

    int n_vec = 0;
    int n_err = 0;

    logic [64:0] m_s [3][LAT];
    bit          m_v [3][LAT];
    logic [64:0] m_sum [3];

    adder_nbit_reg #(.N(1)) u_n1 (
        .clk(clk), .rst(rst), .in_valid(vin), .a(a1), .b(b1), .sum(s1), .out_valid(ov1));
    adder_nbit_reg #(.N(10)) u_n10 (
        .clk(clk), .rst(rst), .in_valid(vin), .a(a10), .b(b10), .sum(s10), .out_valid(ov10));
    adder_nbit_reg #(.N(64)) u_n64 (
        .clk(clk), .rst(rst), .in_valid(vin), .a(a64), .b(b64), .sum(s64), .out_valid(ov64));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_model();
        for (int k = 0; k < 3; k++) begin
            m_sum[k] = '0;
            for (int j = 0; j < LAT; j++) begin
                m_v[k][j] = 1'b0;
                m_s[k][j] = '0;
            end
        end
    endtask

    task automatic chk_all(input string pfx);
        chk({pfx, "_sum1"},  65'(s1),   m_sum[0]);
        chk({pfx, "_sum10"}, 65'(s10),  m_sum[1]);
        chk({pfx, "_sum64"}, s64,       m_sum[2]);
        chk({pfx, "_ov1"},   65'(ov1),  65'(m_v[0][LAT-1]));
        chk({pfx, "_ov10"},  65'(ov10), 65'(m_v[1][LAT-1]));
        chk({pfx, "_ov64"},  65'(ov64), 65'(m_v[2][LAT-1]));
    endtask

    // One clock: the model takes the operands seen at the edge, outputs are sampled 1 later.
    task automatic tick();
        logic [64:0] ns [3];
        @(posedge clk);
        ns[0] = 65'(a1) + 65'(b1);
        ns[1] = 65'(a10) + 65'(b10);
        ns[2] = 65'(a64) + 65'(b64);
        if (rst) clr_model();
        else begin
            for (int k = 0; k < 3; k++) begin
                for (int j = LAT - 1; j >= 1; j--) begin
                    m_v[k][j] = m_v[k][j-1];
                    m_s[k][j] = m_s[k][j-1];
                end
                m_v[k][0] = vin;
                m_s[k][0] = ns[k];
                if (m_v[k][LAT-1]) m_sum[k] = m_s[k][LAT-1];
            end
        end
        #1;
        chk_all("cyc");
    endtask

    task automatic rnd_side();
        a1  = 1'($urandom);
        b1  = 1'($urandom);
        a64 = {$urandom, $urandom};
        b64 = {$urandom, $urandom};
    endtask

    int unsigned da [8] = '{0, 1, 33, 100, 1023, 1023, 512, 5};
    int unsigned db [8] = '{0, 99, 47, 47, 1023, 1, 512, 6};
    int unsigned de [8] = '{0, 100, 80, 147, 2046, 1024, 1024, 11};
    int unsigned e1 [4] = '{0, 1, 1, 2};

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        clr_model();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        clr_model();
        #1;
        chk_all("arst");
        repeat (3) tick();
        rst = 1'b0;

        // Directed N=10 table, back-to-back
        for (int i = 0; i < 8 + LAT - 1; i++) begin
            if (i < 8) begin
                vin = 1'b1;
                a10 = 10'(da[i]);
                b10 = 10'(db[i]);
            end else vin = 1'b0;
            rnd_side();
            tick();
            if (i >= LAT - 1) begin
                chk("dir_sum", 65'(s10), 65'(de[i-LAT+1]));
                chk("dir_ov", 65'(ov10), 65'd1);
            end
        end

        // Idle with junk operands
        for (int i = 0; i < 4; i++) begin
            vin = 1'b0;
            a10 = 'x;
            b10 = 10'($urandom);
            a64 = 'x;
            tick();
            chk("hold_sum", 65'(s10), 65'd11);
            chk("hold_ov", 65'(ov10), 65'd0);
        end

        // N=1 exhaustive
        for (int i = 0; i < 4 + LAT - 1; i++) begin
            if (i < 4) begin
                vin = 1'b1;
                a1 = i[1];
                b1 = i[0];
            end else vin = 1'b0;
            a10 = 10'($urandom);
            b10 = 10'($urandom);
            a64 = {$urandom, $urandom};
            b64 = {$urandom, $urandom};
            tick();
            if (i >= LAT - 1) chk("n1_sum", 65'(s1), 65'(e1[i-LAT+1]));
        end

        // N=64 all-ones
        for (int i = 0; i < LAT; i++) begin
            vin = (i == 0);
            a64 = '1;
            b64 = '1;
            tick();
        end
        chk("max64_sum", s64, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
        chk("max64_ov", 65'(ov64), 65'd1);

        // Reset while 200+300 is in flight
        vin = 1'b1;
        a10 = 10'd200;
        b10 = 10'd300;
        for (int i = 0; i < LAT - 1; i++) tick();
        #2;
        rst = 1'b1;
        clr_model();
        #1;
        chk("flight_arst_sum", 65'(s10), 65'd0);
        tick();
        rst = 1'b0;
        vin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flight_sum", 65'(s10), 65'd0);
            chk("flight_ov", 65'(ov10), 65'd0);
        end

        // Random traffic
        for (int i = 0; i < 1000; i++) begin
            vin = ($urandom_range(0, 3) != 0);
            rnd_side();
            case ($urandom_range(0, 7))
                0:       begin a10 = '1; b10 = '1; end
                1:       begin a10 = '1; b10 = 10'($urandom); end
                default: begin a10 = 10'($urandom); b10 = 10'($urandom); end
            endcase
            if ($urandom_range(0, 15) == 0) begin
                a64 = '1;
                b64 = {$urandom, $urandom};
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
